adc_playback_ctrl: RTL and testbench

Sequencer for the ROM-based multi-channel ADC stimulus path. It drives the shared ROM address and enable for all channel ROMs and tracks the fixed ROM read latency with a tag pipeline. Returned samples go into a small credit-managed FIFO, so the downstream consumer (the FFT BRAM controller) sees a valid/ready stream with frame markers and can apply backpressure without losing samples.

---
 rtl/adc_playback_ctrl.sv | 171 +++++++++++++++++
 tb/tb_adc_playback_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_playback_ctrl.sv
// ROM playback sequencer: shared ROM addressing, LATENCY-deep tag pipeline and a credit-managed output FIFO.
// Define ADC_PLAYBACK_LOOP_EN to make frame_count=0 play continuously until stop; otherwise 0 plays one frame.
module adc_playback_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int DATA_DEPTH = 512,
  parameter int LATENCY    = 2,
  parameter int NUM_CH     = 8,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [15:0]                  frame_count,
  output logic                         rom_en,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] rom_data_i,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  frames_done
);
  localparam int VW         = NUM_CH * DATA_WIDTH;
  localparam int FIFO_DEPTH = LATENCY + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [PW-1:0]         PTR_MAX   = PW'(FIFO_DEPTH - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           target_q, target_d;
  logic                  stop_q, stop_d;
  logic [15:0]           frames_done_q, frames_done_d;
  logic [LATENCY-1:0]    tag_v_q, tag_last_q;
  logic [VW-1:0]         fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fifo_count_q, fifo_count_d;

  logic [CW-1:0] inflight;
  logic          issue, is_last_addr, final_frame, start_acc, wr_en, rd_en, pipe_empty;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(tag_v_q[i]);
  end

  // A read may only issue if its sample is guaranteed a FIFO slot on arrival.
  assign issue        = (state_q == RUN) &&
                        (({1'b0, fifo_count_q} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH));
  assign is_last_addr = (addr_q == LAST_ADDR);
  assign pipe_empty   = (inflight == '0) && (fifo_count_q == '0);
  assign wr_en        = tag_v_q[LATENCY-1];
  assign rd_en        = m_valid && m_ready;

`ifdef ADC_PLAYBACK_LOOP_EN
  assign final_frame = (target_q != 16'd0) && (frame_cnt_q + 16'd1 == target_q);
`else
  assign final_frame = (frame_cnt_q + 16'd1 == target_q);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    frame_cnt_d = frame_cnt_q;
    target_d    = target_q;
    stop_d      = stop_q;
    start_acc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc   = 1'b1;
          state_d     = RUN;
          addr_d      = '0;
          frame_cnt_d = '0;
          stop_d      = 1'b0;
`ifdef ADC_PLAYBACK_LOOP_EN
          target_d    = frame_count;
`else
          target_d    = (frame_count == 16'd0) ? 16'd1 : frame_count;
`endif
        end
      end
      RUN: begin
        if (stop) stop_d = 1'b1;
        if (issue) begin
          addr_d = is_last_addr ? '0 : addr_q + 1'b1;
          if (is_last_addr) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (final_frame || stop_q || stop) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pipe_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_en ? ((wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d     = rd_en ? ((rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (wr_en && !rd_en) fifo_count_d = fifo_count_q + 1'b1;
    else if (!wr_en && rd_en) fifo_count_d = fifo_count_q - 1'b1;
    frames_done_d = frames_done_q;
    if (start_acc) frames_done_d = '0;
    else if (rd_en && m_last && (frames_done_q != 16'hFFFF)) frames_done_d = frames_done_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      frame_cnt_q   <= '0;
      target_q      <= '0;
      stop_q        <= 1'b0;
      frames_done_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
      tag_v_q       <= '0;
      tag_last_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      frame_cnt_q   <= frame_cnt_d;
      target_q      <= target_d;
      stop_q        <= stop_d;
      frames_done_q <= frames_done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      tag_v_q[0]    <= issue;
      tag_last_q[0] <= is_last_addr;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  // Storage needs no reset: the head is only exposed while the FIFO holds data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_data_q[wr_ptr_q] <= rom_data_i;
      fifo_last_q[wr_ptr_q] <= tag_last_q[LATENCY-1];
    end
  end

  assign rom_en      = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign rom_addr    = addr_q;
  assign done        = (state_q == DRAIN) && pipe_empty;
  assign m_valid     = (fifo_count_q != '0);
  assign m_data      = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last      = m_valid && fifo_last_q[rd_ptr_q];
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_adc_playback_ctrl.sv
// Randomized self-checking bench for adc_playback_ctrl; expected streams come from a frame-level model
// (vector k carries the ROM word of address k mod DATA_DEPTH). Honours ADC_PLAYBACK_LOOP_EN when defined.
`timescale 1ns/1ps
module tb_adc_playback_ctrl;
  localparam int DW    = 24;
  localparam int DEPTH = 512;
  localparam int LAT   = 2;
  localparam int NCH   = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int VW    = DW * NCH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, mReady;
  logic [15:0]   frameCount;
  logic          romEn, mValid, mLast, busy, done;
  logic [AW-1:0] romAddr;
  logic [VW-1:0] romData, mData;
  logic [15:0]   framesDone;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int startCycle;
  bit randomReady = 1'b0;

  logic [VW-1:0] popData [$];
  logic          popLast [$];
  int            popCycle [$];
  int            doneCycle [$];
  logic [AW-1:0] addrPipe [LAT];

  adc_playback_ctrl #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .LATENCY(LAT), .NUM_CH(NCH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .frame_count(frameCount),
    .rom_en(romEn), .rom_addr(romAddr), .rom_data_i(romData),
    .m_valid(mValid), .m_ready(mReady), .m_data(mData), .m_last(mLast),
    .busy(busy), .done(done), .frames_done(framesDone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Reference ROM contents: every channel word is distinct per address and channel.
  function automatic logic [VW-1:0] romWord(input int a);
    logic [VW-1:0] w;
    for (int ch = 0; ch < NCH; ch++) w[ch*DW +: DW] = DW'(((ch + 1) << 16) + a * 5 + ch);
    return w;
  endfunction

  // Number of positions where a recorded stream diverges from the frame-level model.
  function automatic int orderErrors(input int base, input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      if (popData[base + k] !== romWord(k % DEPTH) || popLast[base + k] !== ((k % DEPTH) == DEPTH - 1))
        bad++;
    end
    return bad;
  endfunction

  always @(posedge clk) begin
    addrPipe[0] <= romAddr;
    for (int i = 1; i < LAT; i++) addrPipe[i] <= addrPipe[i-1];
  end
  assign romData = romWord(int'(addrPipe[LAT-1]));

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mValid === 1'b1 && mReady === 1'b1) begin
        popData.push_back(mData);
        popLast.push_back(mLast);
        popCycle.push_back(cycleCnt);
      end
      if (done === 1'b1) doneCycle.push_back(cycleCnt);
    end
  end

  initial begin
    mReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic pulseStart(input int fc, input bit withStop);
    @(posedge clk); #1;
    frameCount = 16'(fc);
    start = 1'b1;
    stop = withStop;
    startCycle = cycleCnt;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic pulseStop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic waitPops(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (popData.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; frameCount = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (romEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: romEn=%b busy=%b done=%b, expected 0 0 0", romEn, busy, done);
    end
    checks++;
    if (romAddr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %0d, expected 0", romAddr); end
    checks++;
    if (mValid !== 1'b0 || mLast !== 1'b0 || mData !== '0) begin
      errors++; $display("[TB] FAIL reset_stream: valid=%b last=%b data=%h, expected 0 0 0", mValid, mLast, mData);
    end
    checks++;
    if (framesDone !== 16'd0) begin errors++; $display("[TB] FAIL reset_frames: got %0d, expected 0", framesDone); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int base = popData.size();
    int dBase = doneCycle.size();
    int n, lastPop, firstPop, bad;
    bit ok;
    randomReady = 1'b0;
    pulseStart(1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b, expected 1", busy); end
    waitDone(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL single_timeout: done=0, expected 1"); end
    n = popData.size() - base;
    firstPop = (n > 0) ? popCycle[base] : -1;
    lastPop = (n > 0) ? popCycle[base + n - 1] : -1;
    bad = orderErrors(base, n);
    checks++;
    if (n !== DEPTH) begin errors++; $display("[TB] FAIL single_count: got %0d, expected %0d", n, DEPTH); end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL single_order: got %0d bad vectors, expected 0", bad); end
    checks++;
    if (firstPop !== startCycle + 4) begin
      errors++; $display("[TB] FAIL single_latency: first valid at cycle %0d, expected %0d", firstPop, startCycle + 4);
    end
    checks++;
    if (lastPop !== firstPop + DEPTH - 1) begin
      errors++; $display("[TB] FAIL single_bubbles: last pop at %0d, expected %0d", lastPop, firstPop + DEPTH - 1);
    end
    checks++;
    if (doneCycle.size() - dBase !== 1) begin
      errors++; $display("[TB] FAIL single_done_pulses: got %0d, expected 1", doneCycle.size() - dBase);
    end else begin
      checks++;
      if (doneCycle[dBase] !== lastPop + 1) begin
        errors++; $display("[TB] FAIL single_done_timing: done at %0d, expected %0d", doneCycle[dBase], lastPop + 1);
      end
    end
    checks++;
    if (framesDone !== 16'd1) begin errors++; $display("[TB] FAIL single_frames: got %0d, expected 1", framesDone); end
  endtask

  task automatic test_backpressure();
    int base = popData.size();
    int dBase = doneCycle.size();
    int n, bad;
    bit ok;
    randomReady = 1'b1;
    pulseStart(2, 1'b0);
    waitDone(10000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL bp_timeout: done=0, expected 1"); end
    n = popData.size() - base;
    bad = orderErrors(base, n);
    checks++;
    if (n !== 2 * DEPTH) begin errors++; $display("[TB] FAIL bp_count: got %0d, expected %0d", n, 2 * DEPTH); end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL bp_order: got %0d bad vectors, expected 0", bad); end
    checks++;
    if (framesDone !== 16'd2) begin errors++; $display("[TB] FAIL bp_frames: got %0d, expected 2", framesDone); end
    checks++;
    if (doneCycle.size() - dBase !== 1) begin
      errors++; $display("[TB] FAIL bp_done_pulses: got %0d, expected 1", doneCycle.size() - dBase);
    end
    checks++;
    if (mValid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_idle: valid=%b busy=%b, expected 0 0", mValid, busy);
    end
  endtask

  task automatic test_stop_mid_frame();
    int base = popData.size();
    int dBase = doneCycle.size();
    int n, bad, fc;
    bit ok;
`ifdef ADC_PLAYBACK_LOOP_EN
    fc = 0;
`else
    fc = 5;
`endif
    randomReady = 1'b1;
    pulseStart(fc, 1'b0);
    waitPops(base + 2 * DEPTH + 100, 20000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL stop_reach: got %0d vectors, expected %0d", popData.size() - base, 2 * DEPTH + 100); end
    pulseStop();
    waitDone(20000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL stop_timeout: done=0, expected 1"); end
    n = popData.size() - base;
    bad = orderErrors(base, n);
    checks++;
    if (n !== 3 * DEPTH) begin errors++; $display("[TB] FAIL stop_count: got %0d, expected %0d", n, 3 * DEPTH); end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL stop_order: got %0d bad vectors, expected 0", bad); end
    checks++;
    if (framesDone !== 16'd3) begin errors++; $display("[TB] FAIL stop_frames: got %0d, expected 3", framesDone); end
    checks++;
    if (doneCycle.size() - dBase !== 1) begin
      errors++; $display("[TB] FAIL stop_done_pulses: got %0d, expected 1", doneCycle.size() - dBase);
    end
  endtask

  task automatic test_ignored_controls();
    int base, n, bad;
    bit ok;
    randomReady = 1'b0;
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || romEn !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_stop: busy=%b romEn=%b, expected 0 0", busy, romEn);
    end
    base = popData.size();
    pulseStart(1, 1'b0);
    waitPops(base + 50, 2000, ok);
    @(posedge clk); #1;
    frameCount = 16'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(3000, ok);
    n = popData.size() - base;
    checks++;
    if (!ok || n !== DEPTH) begin
      errors++; $display("[TB] FAIL run_start: got %0d vectors, expected %0d", n, DEPTH);
    end
    checks++;
    if (framesDone !== 16'd1) begin errors++; $display("[TB] FAIL run_start_frames: got %0d, expected 1", framesDone); end
    base = popData.size();
    pulseStart(2, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_stop_busy: got %b, expected 1", busy); end
    waitDone(5000, ok);
    n = popData.size() - base;
    bad = orderErrors(base, n);
    checks++;
    if (!ok || n !== 2 * DEPTH) begin
      errors++; $display("[TB] FAIL start_stop_count: got %0d, expected %0d", n, 2 * DEPTH);
    end
    checks++;
    if (bad !== 0 || framesDone !== 16'd2) begin
      errors++; $display("[TB] FAIL start_stop_stream: bad=%0d frames=%0d, expected 0 and 2", bad, framesDone);
    end
  endtask

  task automatic test_reset_mid_run();
    int base = popData.size();
    int dBase;
    int n, bad;
    bit ok;
    randomReady = 1'b0;
    pulseStart(2, 1'b0);
    waitPops(base + 300, 2000, ok);
    dBase = doneCycle.size();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mValid !== 1'b0 || mLast !== 1'b0 || mData !== '0) begin
      errors++; $display("[TB] FAIL midrst_stream: valid=%b last=%b data=%h, expected 0 0 0", mValid, mLast, mData);
    end
    checks++;
    if (romEn !== 1'b0 || busy !== 1'b0 || romAddr !== '0 || done !== 1'b0 || framesDone !== 16'd0) begin
      errors++; $display("[TB] FAIL midrst_ctrl: romEn=%b busy=%b addr=%0d done=%b frames=%0d, expected 0 0 0 0 0",
                         romEn, busy, romAddr, done, framesDone);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (doneCycle.size() !== dBase) begin
      errors++; $display("[TB] FAIL midrst_done: got %0d pulses, expected 0", doneCycle.size() - dBase);
    end
    base = popData.size();
    pulseStart(1, 1'b0);
    waitDone(3000, ok);
    n = popData.size() - base;
    bad = orderErrors(base, n);
    checks++;
    if (!ok || n !== DEPTH) begin errors++; $display("[TB] FAIL restart_count: got %0d, expected %0d", n, DEPTH); end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL restart_order: got %0d bad vectors, expected 0", bad); end
  endtask

  task automatic test_zero_frames();
    int base = popData.size();
    int n, bad;
    bit ok;
    randomReady = 1'b0;
    pulseStart(0, 1'b0);
`ifdef ADC_PLAYBACK_LOOP_EN
    waitPops(base + DEPTH + 200, 3000, ok);
    checks++;
    if (!ok || busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_continuous: busy=%b, expected 1", busy); end
    pulseStop();
    waitDone(3000, ok);
    n = popData.size() - base;
    bad = orderErrors(base, n);
    checks++;
    if (!ok || n !== 2 * DEPTH) begin errors++; $display("[TB] FAIL zero_count: got %0d, expected %0d", n, 2 * DEPTH); end
    checks++;
    if (bad !== 0 || framesDone !== 16'd2) begin
      errors++; $display("[TB] FAIL zero_stream: bad=%0d frames=%0d, expected 0 and 2", bad, framesDone);
    end
`else
    waitDone(3000, ok);
    n = popData.size() - base;
    bad = orderErrors(base, n);
    checks++;
    if (!ok || n !== DEPTH) begin errors++; $display("[TB] FAIL zero_count: got %0d, expected %0d", n, DEPTH); end
    checks++;
    if (bad !== 0 || framesDone !== 16'd1) begin
      errors++; $display("[TB] FAIL zero_stream: bad=%0d frames=%0d, expected 0 and 1", bad, framesDone);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_stop_mid_frame();
    test_ignored_controls();
    test_reset_mid_run();
    test_zero_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
